linked_list_fifo_reader: RTL and testbench
==========================================

// Module: linked_list_fifo_reader
// PURPOSE
//  Pop-side drain engine for the shared linked_list_fifo (NUM_FIFOS virtual queues, one pool).
//  Round-robin picks a non-empty, enabled queue; drives pop/pop_sel; captures the popped word.
//  Delivers word + queue id downstream on a valid/ready port through a 2-entry skid buffer.
//  Complements the push-side driver/scoreboard harness; same pop contract (no pop when empty).
// PARAMETERS
//  WIDTH      8                  data word width
//  NUM_FIFOS  2                  number of virtual queues in the shared fifo
//  SEL_WIDTH  $clog2(NUM_FIFOS)  queue-select / queue-id width
// PORTS
//  clk        in   1          single clock, rising edge
//  rst        in   1          asynchronous reset, active-high
//  en         in   1          global drain enable; 0 => no new pops
//  qmask      in   NUM_FIFOS  per-queue enable; bit i=0 => queue i never selected
//  empty      in   NUM_FIFOS  per-queue empty flags from shared fifo
//  fifo_data  in   WIDTH      fifo data_out; head of queue pop_sel, combinational
//  pop        out  1          pop strobe to shared fifo
//  pop_sel    out  SEL_WIDTH  queue being popped (meaningful only when pop=1)
//  out_valid  out  1          out_data/out_qid valid
//  out_ready  in   1          downstream accepts when out_valid & out_ready
//  out_data   out  WIDTH      drained word
//  out_qid    out  SEL_WIDTH  queue the word came from
// BEHAVIOUR
//  - Reset (async, immediate): buffer count=0, out_valid=0, out_data=0, out_qid=0, rr_ptr=NUM_FIFOS-1.
//    pop=0 and pop_sel=0 whenever rst=1.
//  - Eligible queue i: en & qmask[i] & ~empty[i].
//  - Grant: first eligible index scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_FIFOS (wrap at NUM_FIFOS-1 -> 0).
//    After reset, queue 0 has first priority.
//  - Space: count<2, or count==2 with out_valid&out_ready in the same cycle.
//  - pop=1 iff a grant exists and space exists. pop_sel=granted index. Both are combinational.
//  - pop is never asserted for an empty queue.
//  - On a pop edge: fifo_data and pop_sel are written to the buffer tail, and rr_ptr<=granted.
//  - Latency: word popped at edge N is on out_data at N+1 if the buffer was empty. No combinational fifo->out path.
//  - Buffer is 2-entry FIFO order. Head drives out_valid/out_data/out_qid.
//    Count update: +1 on pop, -1 on accept, unchanged if both occur.
//  - Handshake: while out_valid=1 & out_ready=0, out_data/out_qid are held stable. out_valid is not withdrawn.
//  - Full buffer (count==2, no accept): pop=0, rr_ptr held.
//  - Throughput: with out_ready=1 continuously, one pop and one output per cycle.
//  - en or qmask deasserted mid-stream: buffered words still drain; only new pops stop.
//  - Empty flag rising on the grant cycle: queue is ineligible that cycle; the scan moves to the next eligible queue.
//  - rst mid-operation: buffered words are discarded, not replayed. The shared fifo is reset on the same rst.
//  - NUM_FIFOS=1: SEL_WIDTH is forced to 1 in use; pop_sel and out_qid are tied 0.
//  - Formal: assert ~(pop & empty[pop_sel]); assert out_data/out_qid stable while out_valid & ~out_ready.
// TESTING
//  1 rst=1 mid-cycle with random inputs -> out_valid=0, pop=0 immediately; rr_ptr=1 (NUM_FIFOS=2).
//  2 q0 holds 0x11,0x22; q1 empty; en=1, qmask=2'b11, out_ready=1 ->
//    pop, pop_sel=0 on 2 consecutive cycles; out 0x11/qid0, then 0x22/qid0, 1 cycle after each pop.
//  3 q0={0xA0,0xA1}, q1={0xB0,0xB1} -> pop_sel 0,1,0,1; outputs A0,B0,A1,B1; qids 0,1,0,1.
//  4 q0 holds 4 words; out_ready=0 -> exactly 2 pops, then pop=0 and out_data held.
//    Then out_ready=1 -> all 4 words exit in order, no gap after the first.
//  5 both queues non-empty, qmask=2'b10 -> only pop_sel=1 popped; q0 untouched.
//    en=0 -> pop=0 while the buffer still drains.
//  6 stream in progress with count=2; assert rst for 1 cycle ->
//    out_valid=0 the same cycle; after release, first grant goes to q0 if q0 is non-empty.

Source files
------------

// File: rtl/linked_list_fifo_reader.sv
// Pop-side drain engine for a shared multi-queue linked-list fifo.
// Round-robin pops eligible queues into a 2-entry skid buffer feeding a valid/ready port.
module linked_list_fifo_reader #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned NUM_FIFOS = 2,
    parameter int unsigned SEL_WIDTH = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [NUM_FIFOS-1:0] qmask,
    input  logic [NUM_FIFOS-1:0] empty,
    input  logic [WIDTH-1:0]     fifo_data,
    output logic                 pop,
    output logic [SEL_WIDTH-1:0] pop_sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_WIDTH-1:0] out_qid
);

    logic [1:0]           count_q, count_d;
    logic [SEL_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0]     head_data_q, head_data_d, tail_data_q, tail_data_d;
    logic [SEL_WIDTH-1:0] head_qid_q, head_qid_d, tail_qid_q, tail_qid_d;

    logic [NUM_FIFOS-1:0] elig;
    logic                 grant_valid;
    logic [SEL_WIDTH-1:0] grant_idx;
    logic                 accept;
    logic                 space;
    logic                 wr_tail;

    assign elig = {NUM_FIFOS{en}} & qmask & ~empty;

    // Scan from farthest to nearest so the nearest eligible index after rr_ptr wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_FIFOS; k >= 1; k--) begin
            int idx;
            idx = (int'(rr_ptr_q) + k) % int'(NUM_FIFOS);
            if (elig[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = SEL_WIDTH'(idx);
            end
        end
    end

    assign out_valid = (count_q != 2'd0);
    assign out_data  = head_data_q;
    assign out_qid   = head_qid_q;
    assign accept    = out_valid & out_ready;
    assign space     = (count_q < 2'd2) | accept;
    assign pop       = grant_valid & space & ~rst;
    assign pop_sel   = rst ? '0 : grant_idx;

    // Tail slot is the write target when one entry remains after any same-cycle accept.
    assign wr_tail = accept ? (count_q == 2'd2) : (count_q == 2'd1);

    always_comb begin
        count_d     = count_q;
        rr_ptr_d    = rr_ptr_q;
        head_data_d = head_data_q;
        head_qid_d  = head_qid_q;
        tail_data_d = tail_data_q;
        tail_qid_d  = tail_qid_q;
        if (accept) begin
            head_data_d = tail_data_q;
            head_qid_d  = tail_qid_q;
        end
        if (pop) begin
            rr_ptr_d = grant_idx;
            if (wr_tail) begin
                tail_data_d = fifo_data;
                tail_qid_d  = grant_idx;
            end else begin
                head_data_d = fifo_data;
                head_qid_d  = grant_idx;
            end
        end
        case ({pop, accept})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= 2'd0;
            rr_ptr_q    <= SEL_WIDTH'(NUM_FIFOS - 1);
            head_data_q <= '0;
            head_qid_q  <= '0;
            tail_data_q <= '0;
            tail_qid_q  <= '0;
        end else begin
            count_q     <= count_d;
            rr_ptr_q    <= rr_ptr_d;
            head_data_q <= head_data_d;
            head_qid_q  <= head_qid_d;
            tail_data_q <= tail_data_d;
            tail_qid_q  <= tail_qid_d;
        end
    end

    a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop && empty[pop_sel]));
    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_qid)));

endmodule

// File: tb/tb_linked_list_fifo_reader.sv
// Directed bench for linked_list_fifo_reader with a two-queue behavioural model of the shared fifo.
module tb_linked_list_fifo_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [1:0] qmask = 2'b00;
    logic [1:0] empty;
    logic [7:0] fifo_data;
    logic       pop;
    logic       pop_sel;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_qid;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [2][8];
    int         rdp [2];
    int         wrp [2];
    int         cnt [2];
    int         ms;

    linked_list_fifo_reader #(.WIDTH(8), .NUM_FIFOS(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .qmask     (qmask),
        .empty     (empty),
        .fifo_data (fifo_data),
        .pop       (pop),
        .pop_sel   (pop_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_qid   (out_qid)
    );

    always #5 clk = ~clk;

    logic [2:0] head_ptr;
    assign head_ptr  = rdp[pop_sel][2:0];
    assign fifo_data = mem[pop_sel][head_ptr];
    assign empty     = {(cnt[1] == 0), (cnt[0] == 0)};

    // Shared-fifo model: consume the head a moment after each popping edge.
    always @(posedge clk) begin
        if (pop && !rst) begin
            ms = int'(pop_sel);
            #1;
            rdp[ms] = rdp[ms] + 1;
            cnt[ms] = cnt[ms] - 1;
        end
    end

    typedef struct {
        logic       en;
        logic [1:0] qmask;
        logic       ready;
        logic       e_pop;
        logic       e_sel;
        logic       e_valid;
        logic [7:0] e_data;
        logic       e_qid;
    } vec_t;

    function automatic vec_t mk(input logic e, input logic [1:0] m, input logic r, input logic p,
                                input logic s, input logic v, input logic [7:0] d, input logic q);
        vec_t t;
        t.en = e; t.qmask = m; t.ready = r; t.e_pop = p;
        t.e_sel = s; t.e_valid = v; t.e_data = d; t.e_qid = q;
        return t;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int q = 0; q < 2; q++) begin
            rdp[q] = 0; wrp[q] = 0; cnt[q] = 0;
            for (int j = 0; j < 8; j++) mem[q][j] = 8'h00;
        end
    endtask

    task automatic push(input int q, input logic [7:0] d);
        mem[q][wrp[q][2:0]] = d;
        wrp[q] = wrp[q] + 1;
        cnt[q] = cnt[q] + 1;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic apply_vec(input vec_t v, input string tag);
        en = v.en; qmask = v.qmask; out_ready = v.ready;
        #1;
        chk({tag, ".pop"}, int'(pop), int'(v.e_pop));
        if (v.e_pop) chk({tag, ".pop_sel"}, int'(pop_sel), int'(v.e_sel));
        chk({tag, ".out_valid"}, int'(out_valid), int'(v.e_valid));
        if (v.e_valid) begin
            chk({tag, ".out_data"}, int'(out_data), int'(v.e_data));
            chk({tag, ".out_qid"}, int'(out_qid), int'(v.e_qid));
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b0; qmask = 2'b00; out_ready = 1'b0;
        clear_model();
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t vt[10];

    initial begin
        // t2: q0={11,22}, q1 empty
        vt[0] = mk(1, 2'b11, 1, 1, 0, 0, 8'h00, 0);
        vt[1] = mk(1, 2'b11, 1, 1, 0, 1, 8'h11, 0);
        vt[2] = mk(1, 2'b11, 1, 0, 0, 1, 8'h22, 0);
        vt[3] = mk(1, 2'b11, 1, 0, 0, 0, 8'h00, 0);
        // t3: round-robin interleave
        vt[4] = mk(1, 2'b11, 1, 1, 0, 0, 8'h00, 0);
        vt[5] = mk(1, 2'b11, 1, 1, 1, 1, 8'hA0, 0);
        vt[6] = mk(1, 2'b11, 1, 1, 0, 1, 8'hB0, 1);
        vt[7] = mk(1, 2'b11, 1, 1, 1, 1, 8'hA1, 0);
        vt[8] = mk(1, 2'b11, 1, 0, 0, 1, 8'hB1, 1);
        vt[9] = mk(1, 2'b11, 1, 0, 0, 0, 8'h00, 0);

        clear_model();
        #2;
        chk("reset.out_valid", int'(out_valid), 0);
        chk("reset.pop", int'(pop), 0);
        chk("reset.out_data", int'(out_data), 0);
        chk("reset.out_qid", int'(out_qid), 0);
        @(negedge clk);
        rst = 1'b0;

        // t1: random activity, then rst asserted mid-cycle
        for (int j = 0; j < 3; j++) begin
            push(0, 8'($urandom));
            push(1, 8'($urandom));
        end
        for (int c = 0; c < 5; c++) begin
            en = 1'($urandom); qmask = 2'($urandom); out_ready = 1'($urandom);
            @(negedge clk);
        end
        en = 1'b1; qmask = 2'b11; out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("t1.rst.out_valid", int'(out_valid), 0);
        chk("t1.rst.pop", int'(pop), 0);
        chk("t1.rst.pop_sel", int'(pop_sel), 0);
        chk("t1.rst.out_data", int'(out_data), 0);
        clear_model();
        push(0, 8'h5A);
        push(1, 8'h6B);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t1.first_grant.pop", int'(pop), 1);
        chk("t1.first_grant.sel", int'(pop_sel), 0);
        @(negedge clk);

        // t2 and t3 from the table
        do_reset();
        push(0, 8'h11); push(0, 8'h22);
        for (int i = 0; i < 4; i++) apply_vec(vt[i], $sformatf("t2[%0d]", i));
        do_reset();
        push(0, 8'hA0); push(0, 8'hA1); push(1, 8'hB0); push(1, 8'hB1);
        for (int i = 4; i < 10; i++) apply_vec(vt[i], $sformatf("t3[%0d]", i));

        // t4: back-pressure fills the buffer, then full-rate drain
        do_reset();
        push(0, 8'hC0); push(0, 8'hC1); push(0, 8'hC2); push(0, 8'hC3);
        apply_vec(mk(1, 2'b11, 0, 1, 0, 0, 8'h00, 0), "t4.c0");
        apply_vec(mk(1, 2'b11, 0, 1, 0, 1, 8'hC0, 0), "t4.c1");
        apply_vec(mk(1, 2'b11, 0, 0, 0, 1, 8'hC0, 0), "t4.c2");
        apply_vec(mk(1, 2'b11, 0, 0, 0, 1, 8'hC0, 0), "t4.c3");
        apply_vec(mk(1, 2'b11, 1, 1, 0, 1, 8'hC0, 0), "t4.c4");
        apply_vec(mk(1, 2'b11, 1, 1, 0, 1, 8'hC1, 0), "t4.c5");
        apply_vec(mk(1, 2'b11, 1, 0, 0, 1, 8'hC2, 0), "t4.c6");
        apply_vec(mk(1, 2'b11, 1, 0, 0, 1, 8'hC3, 0), "t4.c7");
        apply_vec(mk(1, 2'b11, 1, 0, 0, 0, 8'h00, 0), "t4.c8");

        // t5a: qmask excludes q0
        do_reset();
        push(0, 8'hD0); push(0, 8'hD1); push(1, 8'hE0); push(1, 8'hE1);
        apply_vec(mk(1, 2'b10, 1, 1, 1, 0, 8'h00, 0), "t5a.c0");
        apply_vec(mk(1, 2'b10, 1, 1, 1, 1, 8'hE0, 1), "t5a.c1");
        apply_vec(mk(1, 2'b10, 1, 0, 0, 1, 8'hE1, 1), "t5a.c2");
        apply_vec(mk(1, 2'b10, 1, 0, 0, 0, 8'h00, 0), "t5a.c3");
        chk("t5a.q0_untouched", cnt[0], 2);

        // t5b: en drops with a full buffer; buffered words still drain
        do_reset();
        push(0, 8'hF0); push(0, 8'hF1); push(0, 8'hF2);
        apply_vec(mk(1, 2'b11, 0, 1, 0, 0, 8'h00, 0), "t5b.c0");
        apply_vec(mk(1, 2'b11, 0, 1, 0, 1, 8'hF0, 0), "t5b.c1");
        apply_vec(mk(0, 2'b11, 1, 0, 0, 1, 8'hF0, 0), "t5b.c2");
        apply_vec(mk(0, 2'b11, 1, 0, 0, 1, 8'hF1, 0), "t5b.c3");
        apply_vec(mk(0, 2'b11, 1, 0, 0, 0, 8'h00, 0), "t5b.c4");
        chk("t5b.q0_left", cnt[0], 1);

        // t6: rst while full with rr pointing at q0, so q1 would be next without reset
        do_reset();
        push(0, 8'h60); push(0, 8'h61); push(0, 8'h62); push(1, 8'h70);
        apply_vec(mk(1, 2'b01, 0, 1, 0, 0, 8'h00, 0), "t6.c0");
        apply_vec(mk(1, 2'b01, 0, 1, 0, 1, 8'h60, 0), "t6.c1");
        qmask = 2'b11;
        #1;
        chk("t6.full.pop", int'(pop), 0);
        chk("t6.full.out_data", int'(out_data), 8'h60);
        #1;
        rst = 1'b1;
        #1;
        chk("t6.rst.out_valid", int'(out_valid), 0);
        chk("t6.rst.pop", int'(pop), 0);
        clear_model();
        push(0, 8'h80); push(1, 8'h90);
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        apply_vec(mk(1, 2'b11, 1, 1, 0, 0, 8'h00, 0), "t6.post0");
        apply_vec(mk(1, 2'b11, 1, 1, 1, 1, 8'h80, 0), "t6.post1");
        apply_vec(mk(1, 2'b11, 1, 0, 0, 1, 8'h90, 1), "t6.post2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
